// File: rtl/glitc_storage_readout_master_pkg.sv
// Shared definitions for the GLITC storage readout master: STORCTRL bit map, FSM states, address width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package glitc_storage_readout_master_pkg;

    // Sample storage is addressed by an 11-bit word index.
    localparam int SAMPLE_ADDR_W = 11;

    // STORCTRL register bit positions.
    localparam int STOR_TRIG_BIT       = 0;
    localparam int STOR_DONE_BIT       = 1;
    localparam int STOR_CLEAR_BIT      = 2;
    localparam int STOR_SYNC_LATCH_BIT = 3;

    // Command words written to STORCTRL.
    localparam logic [31:0] STOR_TRIG_CMD  = 32'h1 << STOR_TRIG_BIT;
    localparam logic [31:0] STOR_CLEAR_CMD = 32'h1 << STOR_CLEAR_BIT;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_DATA_RD,
        ST_DATA_WAIT,
        ST_PUSH,
        ST_CLEAR,
        ST_FIN
    } rdout_state_t;

endpackage

// File: rtl/glitc_rd_latency_timer.sv
// Loadable down-counter that fires a one-cycle expire pulse RD_LATENCY cycles after load.
// Latency: expire is high in the RD_LATENCY-th cycle after the load cycle.
// Backpressure: none; a new load simply restarts the count.
//  Ports: clk/rst_n (async active-low), load (start count), expire (one-cycle pulse).
module glitc_rd_latency_timer #(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 3'(RD_LATENCY);
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count of 1 is the last waiting cycle: read data is valid now.
    assign expire = (cnt_q == 3'd1);

endmodule

// File: rtl/glitc_storage_readout_master.sv
// Bus initiator: arm capture, poll STORCTRL done, read NWORDS samples to a stream, clear storage.
// Latency: 1 + RD_LATENCY + 1 cycles per word minimum; each poll costs 1 + RD_LATENCY cycles.
// Backpressure: m_ready_i low holds the FSM in PUSH with stream outputs stable and the bus idle.
//  Ports: start_i/busy_o/done_o/timeout_o control; user_* / sample_sel_o bus master with
//  ctrl_dat_i / sample_dat_i read returns; m_dat_o/m_valid_o/m_ready_i/m_last_o stream out.
module glitc_storage_readout_master
    import glitc_storage_readout_master_pkg::*;
#(
    parameter int NWORDS     = 2048,
    parameter int RD_LATENCY = 2,
    parameter int POLL_LIMIT = 4096
) (
    input  logic                     user_clk_i,
    input  logic                     user_rst_n_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     user_sel_o,
    output logic                     sample_sel_o,
    output logic                     user_wr_o,
    output logic                     user_rd_o,
    output logic [SAMPLE_ADDR_W-1:0] user_addr_o,
    output logic [31:0]              user_dat_o,
    input  logic [31:0]              ctrl_dat_i,
    input  logic [31:0]              sample_dat_i,
    output logic [31:0]              m_dat_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o
);

    localparam logic [SAMPLE_ADDR_W-1:0] LAST_ADDR = SAMPLE_ADDR_W'(NWORDS - 1);

    rdout_state_t             state_q, state_d;
    logic [SAMPLE_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]              poll_q, poll_d;
    logic                     abort_q, abort_d;
    logic [31:0]              m_dat_q, m_dat_d;
    logic                     m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                     sel_q, sel_d, ssel_q, ssel_d, wr_q, wr_d, rd_q, rd_d;
    logic [SAMPLE_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]              bus_dat_q, bus_dat_d;
    logic                     busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic                     tmr_load, tmr_expire;
    logic                     unused_ctrl_bits;

    // Only the done flag of STORCTRL matters to the sequencer.
    assign unused_ctrl_bits = ^{ctrl_dat_i[31:STOR_DONE_BIT+1], ctrl_dat_i[STOR_DONE_BIT-1:0]};

    // Every read strobe restarts the shared latency timer.
    assign tmr_load = (state_q == ST_POLL_RD) || (state_q == ST_DATA_RD);

    glitc_rd_latency_timer #(.RD_LATENCY(RD_LATENCY)) u_rd_timer (
        .clk    (user_clk_i),
        .rst_n  (user_rst_n_i),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        poll_d  = poll_q;
        abort_d = abort_q;
        m_dat_d = m_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ARM;
                    poll_d  = 16'd0;
                    abort_d = 1'b0;
                end
            end
            ST_ARM:     state_d = ST_POLL_RD;
            ST_POLL_RD: begin
                poll_d  = poll_q + 16'd1;
                state_d = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (tmr_expire) begin
                    if (ctrl_dat_i[STOR_DONE_BIT]) begin
                        addr_d  = '0;
                        state_d = ST_DATA_RD;
                    end else if (poll_q == 16'(POLL_LIMIT)) begin
                        abort_d = 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_POLL_RD;
                    end
                end
            end
            ST_DATA_RD: state_d = ST_DATA_WAIT;
            ST_DATA_WAIT: begin
                if (tmr_expire) begin
                    m_dat_d = sample_dat_i;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (m_ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_CLEAR;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_DATA_RD;
                    end
                end
            end
            ST_CLEAR: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly
        // and line up with state_q in the following cycle.
        sel_d      = (state_d == ST_ARM) || (state_d == ST_POLL_RD) || (state_d == ST_CLEAR);
        ssel_d     = (state_d == ST_DATA_RD);
        wr_d       = (state_d == ST_ARM) || (state_d == ST_CLEAR);
        rd_d       = (state_d == ST_POLL_RD) || (state_d == ST_DATA_RD);
        bus_addr_d = (state_d == ST_DATA_RD) ? addr_d : '0;
        bus_dat_d  = (state_d == ST_ARM)   ? STOR_TRIG_CMD  :
                     (state_d == ST_CLEAR) ? STOR_CLEAR_CMD : 32'h0;
        m_valid_d  = (state_d == ST_PUSH);
        m_last_d   = (state_d == ST_PUSH) && (addr_d == LAST_ADDR);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN) && !abort_d;
        timeout_d  = (state_d == ST_FIN) && abort_d;
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            poll_q     <= 16'd0;
            abort_q    <= 1'b0;
            m_dat_q    <= 32'h0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            sel_q      <= 1'b0;
            ssel_q     <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            bus_addr_q <= '0;
            bus_dat_q  <= 32'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            poll_q     <= poll_d;
            abort_q    <= abort_d;
            m_dat_q    <= m_dat_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            sel_q      <= sel_d;
            ssel_q     <= ssel_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            bus_addr_q <= bus_addr_d;
            bus_dat_q  <= bus_dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign user_sel_o   = sel_q;
    assign sample_sel_o = ssel_q;
    assign user_wr_o    = wr_q;
    assign user_rd_o    = rd_q;
    assign user_addr_o  = bus_addr_q;
    assign user_dat_o   = bus_dat_q;
    assign m_dat_o      = m_dat_q;
    assign m_valid_o    = m_valid_q;
    assign m_last_o     = m_last_q;

endmodule

// File: tb/tb_glitc_storage_readout_master.sv
// Bench for glitc_storage_readout_master: three DUT configurations, bus/storage model, stream scoreboard.
// Latency: n/a.
// Backpressure: instance 0 stream ready is randomised at 30% duty in one phase.
module tb_glitc_storage_readout_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n [3];
    logic        start [3];
    logic        ready [3];
    logic        busy [3], done [3], tmo [3], sel [3], ssel [3], wr [3], rd [3], vld [3], last [3];
    logic [10:0] addr [3];
    logic [31:0] wdat [3], mdat [3];
    logic [31:0] cdat [3] = '{default: 32'h0};
    logic [31:0] sdat [3] = '{default: 32'h0};
    int          done_after [3];
    int          rdy_mode = 0;

    // Event counters maintained by the bus/stream model (cumulative).
    int n_trig [3] = '{default: 0};
    int n_clr  [3] = '{default: 0};
    int n_poll [3] = '{default: 0};
    int n_beat [3] = '{default: 0};
    int n_last [3] = '{default: 0};
    int n_done [3] = '{default: 0};
    int n_to   [3] = '{default: 0};
    int n_edat [3] = '{default: 0};
    int n_estb [3] = '{default: 0};
    int n_ebus [3] = '{default: 0};
    int n_ovl  [3] = '{default: 0};
    int gap_min [3] = '{default: 0};
    int gap_max [3] = '{default: 0};

    int n_vec = 0;
    int n_bad = 0;

    // Sample storage content: word a holds a scrambled copy of its address.
    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int NW  = (gi == 0) ? 2048 : 8;
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 7);
        localparam int PL  = (gi == 0) ? 4096 : 16;

        glitc_storage_readout_master #(
            .NWORDS(NW), .RD_LATENCY(LAT), .POLL_LIMIT(PL)
        ) u_dut (
            .user_clk_i   (clk),
            .user_rst_n_i (rst_n[gi]),
            .start_i      (start[gi]),
            .busy_o       (busy[gi]),
            .done_o       (done[gi]),
            .timeout_o    (tmo[gi]),
            .user_sel_o   (sel[gi]),
            .sample_sel_o (ssel[gi]),
            .user_wr_o    (wr[gi]),
            .user_rd_o    (rd[gi]),
            .user_addr_o  (addr[gi]),
            .user_dat_o   (wdat[gi]),
            .ctrl_dat_i   (cdat[gi]),
            .sample_dat_i (sdat[gi]),
            .m_dat_o      (mdat[gi]),
            .m_valid_o    (vld[gi]),
            .m_ready_i    (ready[gi]),
            .m_last_o     (last[gi])
        );

        // Read-return pipe: kind 1 = STORCTRL, 2 = sample; data appears exactly LAT cycles after the strobe.
        logic [1:0]  pk [LAT];
        logic [31:0] pd [LAT];
        int          cap_polls = 0;
        int          beat_idx  = 0;
        int          last_cyc  = 0;
        logic        in_seq = 1'b0, stall_q = 1'b0, stall_last = 1'b0, pulse_prev = 1'b0;
        logic [31:0] stall_dat = 32'h0;

        always @(negedge clk) begin
            if (!rst_n[gi]) begin
                for (int k = 0; k < LAT; k++) pk[k] <= 2'd0;
                cap_polls <= 0;
                beat_idx  <= 0;
                in_seq    <= 1'b0;
                stall_q   <= 1'b0;
                pulse_prev <= 1'b0;
            end else begin
                for (int k = LAT - 1; k > 0; k--) begin
                    pk[k] <= pk[k-1];
                    pd[k] <= pd[k-1];
                end
                pk[0] <= 2'd0;
                pd[0] <= $urandom;
                cdat[gi] <= (pk[LAT-1] == 2'd1) ? pd[LAT-1] : $urandom;
                sdat[gi] <= (pk[LAT-1] == 2'd2) ? pd[LAT-1] : $urandom;

                // Bus protocol rules.
                if (!wr[gi] && wdat[gi] != 32'h0) n_ebus[gi] <= n_ebus[gi] + 1;
                if (!(rd[gi] && ssel[gi]) && addr[gi] != 11'd0) n_ebus[gi] <= n_ebus[gi] + 1;
                if (sel[gi] && ssel[gi]) n_ebus[gi] <= n_ebus[gi] + 1;
                if (wr[gi] && (rd[gi] || ssel[gi])) n_ebus[gi] <= n_ebus[gi] + 1;
                if ((wr[gi] || rd[gi]) && !(sel[gi] || ssel[gi])) n_ebus[gi] <= n_ebus[gi] + 1;
                if (rd[gi]) begin
                    for (int k = 0; k < LAT; k++)
                        if (pk[k] != 2'd0) n_ebus[gi] <= n_ebus[gi] + 1;
                end

                if (rd[gi] && sel[gi]) begin
                    pk[0] <= 2'd1;
                    pd[0] <= ($urandom & ~32'h2) | ((cap_polls + 1 >= done_after[gi]) ? 32'h2 : 32'h0);
                    cap_polls <= cap_polls + 1;
                    n_poll[gi] <= n_poll[gi] + 1;
                end
                if (rd[gi] && ssel[gi]) begin
                    pk[0] <= 2'd2;
                    pd[0] <= pat(int'(addr[gi]));
                end

                if (wr[gi] && sel[gi]) begin
                    if (wdat[gi] == 32'h1) begin
                        n_trig[gi] <= n_trig[gi] + 1;
                        if (in_seq) n_ovl[gi] <= n_ovl[gi] + 1;
                        in_seq <= 1'b1;
                        cap_polls <= 0;
                        gap_min[gi] <= 1 << 30;
                        gap_max[gi] <= 0;
                    end else if (wdat[gi] == 32'h4) begin
                        n_clr[gi] <= n_clr[gi] + 1;
                        in_seq <= 1'b0;
                    end else begin
                        n_ebus[gi] <= n_ebus[gi] + 1;
                    end
                end

                // Stream: stability under stall, no reads while a beat is pending.
                if (stall_q && (!vld[gi] || mdat[gi] != stall_dat || last[gi] != stall_last))
                    n_estb[gi] <= n_estb[gi] + 1;
                if (rd[gi] && vld[gi]) n_estb[gi] <= n_estb[gi] + 1;
                stall_q    <= vld[gi] && !ready[gi];
                stall_dat  <= mdat[gi];
                stall_last <= last[gi];

                if (vld[gi] && ready[gi]) begin
                    if (mdat[gi] != pat(beat_idx) || last[gi] != (beat_idx == NW - 1))
                        n_edat[gi] <= n_edat[gi] + 1;
                    n_beat[gi] <= n_beat[gi] + 1;
                    if (last[gi]) n_last[gi] <= n_last[gi] + 1;
                    beat_idx <= (beat_idx == NW - 1) ? 0 : beat_idx + 1;
                    if (beat_idx != 0) begin
                        if (cyc - last_cyc < gap_min[gi]) gap_min[gi] <= cyc - last_cyc;
                        if (cyc - last_cyc > gap_max[gi]) gap_max[gi] <= cyc - last_cyc;
                    end
                    last_cyc <= cyc;
                end

                if (done[gi]) n_done[gi] <= n_done[gi] + 1;
                if (tmo[gi])  n_to[gi]   <= n_to[gi] + 1;
                if ((done[gi] || tmo[gi]) && pulse_prev) n_ebus[gi] <= n_ebus[gi] + 1;
                pulse_prev <= done[gi] || tmo[gi];
            end
        end
    end

    initial begin
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        ready[2] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready[0] = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
        end
    end

    int b_trig, b_clr, b_poll, b_beat, b_last, b_done, b_to, b_edat, b_estb, b_ebus, b_ovl;

    task automatic snap(input int i);
        b_trig = n_trig[i]; b_clr = n_clr[i]; b_poll = n_poll[i]; b_beat = n_beat[i];
        b_last = n_last[i]; b_done = n_done[i]; b_to = n_to[i]; b_edat = n_edat[i];
        b_estb = n_estb[i]; b_ebus = n_ebus[i]; b_ovl = n_ovl[i];
    endtask

    task automatic wait_idle(input int i, input int budget, input string tag);
        int n = 0;
        while (busy[i] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_finish"}, busy[i], 0);
    endtask

    task automatic run_cap(input int i, input int budget, input string tag);
        @(posedge clk);
        #1 start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
        check({tag, "_busy"}, busy[i], 1);
        wait_idle(i, budget, tag);
    endtask

    task automatic chk_idle(input int i, input string tag);
        check({tag, "_ctl"}, {busy[i], done[i], tmo[i], sel[i], ssel[i], wr[i], rd[i], vld[i], last[i]}, 0);
        check({tag, "_addr"}, addr[i], 0);
        check({tag, "_wdat"}, wdat[i], 0);
        check({tag, "_mdat"}, mdat[i], 0);
    endtask

    // Outcome of one capture relative to the last snapshot.
    task automatic chk_cap(input int i, input string tag, input int polls, input int beats,
                           input int dn, input int to);
        check({tag, "_trig"},  n_trig[i] - b_trig, 1);
        check({tag, "_polls"}, n_poll[i] - b_poll, polls);
        check({tag, "_beats"}, n_beat[i] - b_beat, beats);
        check({tag, "_last"},  n_last[i] - b_last, (beats > 0) ? 1 : 0);
        check({tag, "_clear"}, n_clr[i] - b_clr, 1);
        check({tag, "_done"},  n_done[i] - b_done, dn);
        check({tag, "_tmo"},   n_to[i] - b_to, to);
        check({tag, "_data"},  n_edat[i] - b_edat, 0);
        check({tag, "_bus"},   n_ebus[i] - b_ebus, 0);
        check({tag, "_stall"}, n_estb[i] - b_estb, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1;
            start[i] = 1'b0;
        end
        done_after[0] = 10;
        done_after[1] = 1000000;
        done_after[2] = 2;
        #2;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal capture, done on the 10th poll, ready held high.
        snap(0);
        run_cap(0, 20000, "t1");
        chk_cap(0, "t1", 10, 2048, 1, 0);
        check("t1_gap_min", gap_min[0], 4);
        check("t1_gap_max", gap_max[0], 4);

        // Backpressure at 30% ready duty.
        done_after[0] = 3;
        rdy_mode = 1;
        snap(0);
        run_cap(0, 60000, "t2");
        chk_cap(0, "t2", 3, 2048, 1, 0);
        rdy_mode = 0;

        // Timeout: done never reported, POLL_LIMIT = 16.
        snap(1);
        run_cap(1, 2000, "t3");
        chk_cap(1, "t3", 16, 0, 0, 1);

        // Reset in the middle of the readout.
        done_after[0] = 2;
        snap(0);
        @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        n = 0;
        while (n_beat[0] - b_beat < 700 && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_reach700", n_beat[0] - b_beat, 700);
        rst_n[0] = 1'b0;
        #1;
        chk_idle(0, "t4_rst");
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_clear", n_clr[0] - b_clr, 0);
        check("t4_no_done", n_done[0] - b_done, 0);
        rst_n[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t4_idle", busy[0], 0);
        snap(0);
        run_cap(0, 20000, "t4");
        chk_cap(0, "t4", 2, 2048, 1, 0);

        // start_i held high across captures.
        done_after[1] = 2;
        snap(1);
        @(posedge clk);
        #1 start[1] = 1'b1;
        n = 0;
        while (n_done[1] - b_done < 2 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        start[1] = 1'b0;
        wait_idle(1, 1000, "t5");
        check("t5_caps", n_done[1] - b_done, 2);
        check("t5_trig", n_trig[1] - b_trig, n_done[1] - b_done);
        check("t5_overlap", n_ovl[1] - b_ovl, 0);
        check("t5_data", n_edat[1] - b_edat, 0);
        check("t5_bus", n_ebus[1] - b_ebus, 0);

        // Latency extremes with NWORDS = 8.
        snap(1);
        run_cap(1, 2000, "t6a");
        chk_cap(1, "t6a", 2, 8, 1, 0);
        check("t6a_gap_min", gap_min[1], 3);
        check("t6a_gap_max", gap_max[1], 3);
        snap(2);
        run_cap(2, 2000, "t6b");
        chk_cap(2, "t6b", 2, 8, 1, 0);
        check("t6b_gap_min", gap_min[2], 9);
        check("t6b_gap_max", gap_max[2], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
